mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Shares one sequential shift-add multiplier between N_REQ requesters.
//  A round-robin arbiter grants one operand pair at a time and runs WIDTH add/shift steps.
//  The result is returned with the winning requester's id on a valid/ready response port.
//  Sits between client blocks and the arithmetic datapath; no client needs its own multiplier.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  WIDTH  4  operand width; product is 2*WIDTH
//  IDW    2  width of resp_id, = clog2(N_REQ)
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous active-low reset
//  req_valid     in   N_REQ       per-requester operand valid
//  req_ready     out  N_REQ       per-requester accept (one-hot or zero)
//  req_a         in   N_REQ*WIDTH multiplicands, requester i at [i*WIDTH +: WIDTH]
//  req_b         in   N_REQ*WIDTH multipliers, same packing
//  resp_valid    out  1           result valid
//  resp_ready    in   1           consumer accepts result
//  resp_id       out  IDW         index of requester that owns resp_product
//  resp_product  out  2*WIDTH     unsigned product A*B
//  busy          out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; req_ready=0; resp_valid=0; resp_id=0.
//   Also on reset: resp_product=0; busy=0; rr pointer last=N_REQ-1 (req 0 has top priority).
//  FSM has three states: IDLE, RUN, DONE.
//  IDLE: search starts at last+1 and wraps modulo N_REQ; the first i with req_valid[i]=1 wins.
//   IDLE grant: req_ready[i]=1 (combinational, same cycle); other req_ready bits are 0.
//   IDLE on handshake: latch a=req_a[i] and id=i; acc<={(WIDTH+1)'b0, req_b[i]}; cnt<=0; ->RUN.
//   IDLE with no req_valid: stay in IDLE; req_ready=0.
//  RUN (req_ready=0): each cycle acc[2W:W] <= acc[2W:W+1] + (acc[0] ? a : 0).
//   In the same cycle acc[W-1:0] <= acc[W:1]; the adder is WIDTH+1 bits wide and keeps the carry.
//   When cnt==WIDTH-1 the step is the last one: -> DONE; cnt increments otherwise.
//  DONE: resp_valid=1; resp_product=acc[2W-1:0] and resp_id=id stay stable until the handshake.
//   DONE with resp_ready=1: -> IDLE, last<=id; resp_valid deasserts the next cycle.
//   DONE with resp_ready=0: hold indefinitely (backpressure); no new request is accepted.
//  Latency: handshake in cycle T gives resp_valid in cycle T+WIDTH+1.
//   Back-to-back accepts are at least WIDTH+2 cycles apart.
//  Requesters may drop req_valid before their grant; nothing is latched for them.
//   Operands are sampled only in the handshake cycle.
//  resp_ready in IDLE or RUN is ignored.
//  Reset mid-RUN/DONE: the operation is aborted and the result discarded; no resp_valid.
//  Full range is exact: max*max = (2^W-1)^2; for W=4, 15*15=225=8'hE1.
//  Fairness: a requester that holds req_valid is granted within N_REQ grants.
// CONFIGURATION
//  MULT_ZERO_SKIP_EN defined: if the latched a==0 or b==0 at the handshake, skip RUN.
//   Go IDLE->DONE directly with acc=0; latency is 1 cycle (resp_valid at T+1).
//  MULT_ZERO_SKIP_EN undefined: every operation takes the full WIDTH RUN cycles.
// TESTING
//  Single op: req_valid=4'b0001, A=4'd13, B=4'd11 -> req_ready[0]=1 for 1 cycle.
//   Then resp_valid at T+5 with product=8'd143 and id=0.
//  Round-robin: all 4 valid continuously, resp_ready=1 -> grant order 0,1,2,3,0.
//   Each grant is WIDTH+2=6 cycles apart.
//  Backpressure: hold resp_ready=0 for 10 cycles in DONE.
//   Required: product/id stable; req_ready stays 0; busy=1; release -> IDLE next cycle.
//  Corners, all requester 2: 15*15 -> 8'd225; 0*9 -> 0 (with MULT_ZERO_SKIP_EN: resp_valid at T+1).
//   Also 1*15 -> 8'd15 and 8*2 -> 8'd16.
//  Reset mid-RUN: assert rst_n=0 asynchronously at cycle T+2.
//   Required: resp_valid=0, busy=0 immediately; after release, req 0 has top priority.
//  Sparse and dropped requests: req 3 valid for 1 cycle while busy, then drops -> never granted.
//   Requester 1 then gets the next grant.

Source files
------------

// File: rtl/mult_rr_scheduler_if.sv
// Request/response bundle for mult_rr_scheduler.
// master: client side (drives operands and resp_ready).
// slave : scheduler side (drives grants, results and busy).
`timescale 1ns/1ps
interface mult_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [2*WIDTH-1:0]     resp_product;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, busy
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one sequential shift-add multiplier among
// N_REQ requesters. The winner's operands are latched, WIDTH add/shift steps
// run, and the product is returned with the winner's id on a valid/ready port.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand skips the RUN phase
// and the (zero) result is offered one cycle after the handshake.
`timescale 1ns/1ps
module mult_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_rr_scheduler_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_last;
    logic [IDW-1:0]       r_id;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_a;
    // Product register: upper half accumulates partial sums, lower half
    // initially holds the multiplier and is shifted out LSB first.
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_gnt_vld;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_zero_op;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_gnt_vld && bus.req_valid[IDW'((int'(r_last) + k) % N_REQ)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDW'((int'(r_last) + k) % N_REQ);
            end
        end
    end

    // Winner operand selection and datapath step arithmetic.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && w_gnt_vld;
        w_sel_a     = bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
        w_sel_b     = bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
        w_last_step = (r_cnt == CW'(WIDTH - 1));
`ifdef MULT_ZERO_SKIP_EN
        w_zero_op   = (w_sel_a == '0) || (w_sel_b == '0);
`else
        w_zero_op   = 1'b0;
`endif
        w_addend    = r_acc[0] ? r_a : '0;
        // Carry out of the upper half is kept and shifted into the top bit.
        w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_zero_op ? S_DONE : S_RUN;
            S_RUN:   if (w_last_step) w_next = S_DONE;
            S_DONE:  if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: one-hot grant in IDLE, result port, busy flag.
    always_comb begin
        bus.req_ready = '0;
        if (w_accept) begin
            bus.req_ready[w_gnt_idx] = 1'b1;
        end
        bus.resp_valid   = (r_state == S_DONE);
        bus.busy         = (r_state != S_IDLE);
        bus.resp_id      = r_id;
        bus.resp_product = r_acc;
    end

    // Arbitration pointer, owner id, step counter and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IDW'(N_REQ - 1);
            r_id   <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_gnt_idx;
                        r_cnt <= '0;
                        r_acc <= w_zero_op ? '0 : {{WIDTH{1'b0}}, w_sel_b};
                    end
                end
                S_RUN: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    if (!w_last_step) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        r_last <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Multiplicand is only meaningful after a handshake, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= w_sel_a;
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler: every grant pushes the expected
// product/id/latency, every response handshake pops and compares.
`timescale 1ns/1ps
module tb_mult_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    typedef struct {
        int id;
        int prod;
        int cyc;
        int lat;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } gnt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   resp_seen = 1'b0;
    exp_t sb_q[$];
    gnt_t gnt_log[$];
    exp_t mon_e;
    int   mon_g;
    int   mon_a;
    int   mon_b;
    int   mon_lat;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mult_rr_scheduler_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    mult_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((bus.req_valid & bus.req_ready) != '0) begin
                mon_g = 0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (bus.req_ready[i]) mon_g = i;
                end
                chk("rdy_onehot", 32'($onehot(bus.req_ready)), 1);
                mon_a   = int'(bus.req_a[mon_g*WIDTH +: WIDTH]);
                mon_b   = int'(bus.req_b[mon_g*WIDTH +: WIDTH]);
                mon_lat = WIDTH + 1;
`ifdef MULT_ZERO_SKIP_EN
                if (mon_a == 0 || mon_b == 0) mon_lat = 1;
`endif
                sb_q.push_back('{mon_g, mon_a * mon_b, cyc, mon_lat});
                gnt_log.push_back('{mon_g, cyc});
            end
            if (bus.resp_valid && !resp_seen) begin
                resp_seen = 1'b1;
                if (sb_q.size() > 0) chk("latency", 32'(cyc - sb_q[0].cyc), 32'(sb_q[0].lat));
            end
            if (bus.resp_valid && bus.resp_ready) begin
                chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    chk("product", 32'(bus.resp_product), 32'(mon_e.prod));
                    chk("resp_id", 32'(bus.resp_id), 32'(mon_e.id));
                end
                resp_seen = 1'b0;
            end
        end
    end

    task automatic set_ops(input int idx, input int a, input int b);
        bus.req_a[idx*WIDTH +: WIDTH] = WIDTH'(a);
        bus.req_b[idx*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    // Raise one request, wait (bounded) for its grant, then drop it.
    task automatic do_req(input int idx, input int a, input int b);
        bit got = 1'b0;
        set_ops(idx, a, b);
        bus.req_valid[idx] = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) got = 1'b1;
        end
        chk("grant_wait", 32'(got), 1);
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!bus.busy && !bus.resp_valid && sb_q.size() == 0) done = 1'b1;
        end
        chk("drain", 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n3;
        bit got;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_id", 32'(bus.resp_id), 0);
        chk("rst_product", 32'(bus.resp_product), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin with every requester continuously valid.
        for (int i = 0; i < N_REQ; i++) set_ops(i, i + 3, 2*i + 5);
        base = gnt_log.size();
        bus.req_valid = '1;
        for (int k = 0; k < 100 && gnt_log.size() < base + 5; k++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("rr_count", 32'(gnt_log.size() - base), 5);
        for (int k = 0; k < 5 && base + k < gnt_log.size(); k++)
            chk("rr_order", 32'(gnt_log[base+k].id), 32'(k % N_REQ));
        for (int k = 1; k < 5 && base + k < gnt_log.size(); k++)
            chk("rr_gap", 32'(gnt_log[base+k].cyc - gnt_log[base+k-1].cyc), WIDTH + 2);
        wait_drain();

        // Single operation, 13*11.
        do_req(0, 13, 11);
        wait_drain();

        // Backpressure in DONE while another requester waits.
        bus.resp_ready = 1'b0;
        do_req(1, 7, 9);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (bus.resp_valid) got = 1'b1;
        end
        chk("bp_valid_wait", 32'(got), 1);
        @(posedge clk);
        #1;
        set_ops(2, 5, 5);
        bus.req_valid[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 1);
            chk("bp_product", 32'(bus.resp_product), 63);
            chk("bp_id", 32'(bus.resp_id), 1);
            chk("bp_req_ready", 32'(bus.req_ready), 0);
            chk("bp_busy", 32'(bus.busy), 1);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", 32'(bus.busy), 0);
        chk("bp_next_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        wait_drain();

        // Corner operands on requester 2.
        do_req(2, 15, 15);
        wait_drain();
        do_req(2, 0, 9);
        wait_drain();
        do_req(2, 1, 15);
        wait_drain();
        do_req(2, 8, 2);
        wait_drain();

        // Asynchronous reset in the middle of RUN.
        do_req(3, 6, 7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(bus.resp_valid), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        sb_q.delete();
        resp_seen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) set_ops(i, i + 2, 3);
        bus.req_valid = '1;
        @(negedge clk);
        chk("postrst_grant", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        wait_drain();

        // Requester 3 pulses for one cycle while busy and must never win.
        do_req(2, 3, 3);
        base = gnt_log.size();
        @(posedge clk);
        #1;
        set_ops(3, 4, 4);
        bus.req_valid[3] = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        set_ops(1, 9, 4);
        bus.req_valid[1] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[1]) got = 1'b1;
        end
        chk("sparse_grant_wait", 32'(got), 1);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        n3 = 0;
        for (int k = base; k < gnt_log.size(); k++) if (gnt_log[k].id == 3) n3++;
        chk("sparse_drop", 32'(n3), 0);
        if (gnt_log.size() > base) chk("sparse_next", 32'(gnt_log[base].id), 1);
        else chk("sparse_next_count", 32'(gnt_log.size() - base), 1);
        wait_drain();

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
